rf_param: RTL and testbench
===========================

Name: rf_param

Overview:
- Parametrised register file for the 8-bit teaching-core datapath.
- Provides one write port and two read ports (A, B), a constant bypass on B, a zero register at index 0, a separate overflow flag register, and a store-value read of the write-pointer register.
- After reset, a sequential clear sweep zeroes the array so that it can map onto RAM-style storage.
- Sits between decode and the ALU; the writeback stage drives the write port.

Parameters:
- W, 8, data width in bits.
- DEPTH, 8, number of registers (power of two, at least 2).
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- we  in  1  write enable.
- ptr_w  in  AW  write pointer; also selects store_value.
- di  in  W  write data.
- ptr_a  in  AW  read pointer A.
- ptr_b  in  W  read pointer B, or the constant when const_flag=1; the pointer is ptr_b[AW-1:0].
- const_flag  in  1  when 1, do_b = ptr_b.
- flag_we  in  1  overflow flag write enable.
- flag_in  in  1  new overflow flag value (r_overflow from the ALU).
- do_a  out  W  read data A.
- do_b  out  W  read data B.
- store_value  out  W  contents of core[ptr_w], for stores.
- flag_out  out  1  overflow flag register.
- ready  out  1  1 when the clear sweep is done and the file is usable.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Storage is core[DEPTH] of W bits plus a separate flag flop. The flag is never aliased into core.
- FSM states: CLEAR, RUN.
  - reset=1 at a posedge: next state CLEAR, clr_cnt=1, flag_out=0, ready=0.
  - CLEAR: each cycle write core[clr_cnt]=0 and increment clr_cnt. When clr_cnt==DEPTH-1, write it and go to RUN on the next edge.
  - The sweep takes DEPTH-1 cycles after reset deasserts. Index 0 is not swept because it is hardwired to zero.
  - RUN: ready=1. Only reset leaves RUN.
- Reset asserted mid-sweep or during RUN restarts the sweep at clr_cnt=1. Contents are then undefined until ready=1.
- While in CLEAR:
  - we and flag_we are ignored.
  - do_a, do_b and store_value read 0, except do_b=ptr_b when const_flag=1.
- Write (RUN): at the posedge with we=1 and ptr_w!=0, core[ptr_w]<=di. Writes with ptr_w==0 are discarded.
- Reads are combinational (0 cycles):
  - do_a = 0 if ptr_a==0, else core[ptr_a].
  - do_b = ptr_b if const_flag=1; else 0 if ptr_b[AW-1:0]==0; else core[ptr_b[AW-1:0]].
  - Upper bits of ptr_b are ignored when const_flag=0.
  - store_value = 0 if ptr_w==0, else core[ptr_w].
- Flag (RUN): at the posedge with flag_we=1, flag_out<=flag_in; otherwise it holds. A simultaneous we and flag_we are independent and both take effect.
- A write and a read of the same index in the same cycle return the old value unless RF_FORWARD_EN is defined.
- No width conversion; all data paths are W bits.

Optional Feature:
- Macro: RF_FORWARD_EN.
- Defined: when we=1 in RUN, ptr_w!=0 and a read pointer matches ptr_w, that read port returns di in the same cycle. This applies to do_a, do_b (non-constant only) and store_value. flag_out also forwards flag_in when flag_we=1.
- Undefined: reads return the registered contents (old value).

Decomposition:
- Package rf_pkg holds:
  - typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
  - localparam ZERO_REG=0.
- Sub-module rf_clear_seq: the FSM and clr_cnt, with outputs clr_we, clr_addr and ready.
- The array, read muxing and forwarding stay in rf_param.

Test Plan:
1. Reset: hold reset 2 cycles, release, count cycles to ready=1 (must be 7 with DEPTH=8). Then read all pointers: all 0, and flag_out=0.
2. Write and read: write core[3]=0xA5 and core[7]=0x3C. Set ptr_a=3 and ptr_b=7 with const_flag=0: do_a=0xA5, do_b=0x3C. Set ptr_w=3: store_value=0xA5.
3. Zero register and constant: write ptr_w=0 with di=0xFF, then ptr_a=0 gives do_a=0. Set const_flag=1 with ptr_b=0x9B: do_b=0x9B. Set const_flag=0 with ptr_b=0xFB: do_b=core[3].
4. Flag: flag_we=1, flag_in=1 gives flag_out=1 next cycle and holds with flag_we=0. In the same cycle, we=1 writing core[2]=0x11 results in both updated.
5. Reset mid-sweep: assert reset at cycle 3 of the sweep. ready stays 0 for 7 cycles after release; we=1 during the sweep leaves core unchanged.
6. Same-cycle read/write: core[5]=0x10, then we=1 writing ptr_w=5, di=0x20 with ptr_a=5. do_a=0x10 without the macro, 0x20 with RF_FORWARD_EN; the next cycle gives 0x20 in both builds.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the rf_param register file.
package rf_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: sweeps indices 1..DEPTH-1 with zero writes, then raises ready.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  rf_state_t     r_state;
  logic [AW-1:0] r_clr_cnt;
  logic          r_clr_we;
  logic          r_ready;

  // Index 0 is hardwired to zero, so the sweep starts at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RF_CLEAR;
      r_clr_cnt <= AW'(1);
      r_clr_we  <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + AW'(1);
          if (r_clr_cnt == AW'(DEPTH - 1)) begin
            r_state  <= RF_RUN;
            r_clr_we <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        RF_RUN: begin
          r_clr_we <= 1'b0;
          r_ready  <= 1'b1;
        end
        default: begin
          r_state  <= RF_CLEAR;
          r_clr_we <= 1'b1;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = r_clr_we;
  assign clr_addr = r_clr_cnt;
  assign ready    = r_ready;

endmodule

// File: rtl/rf_param.sv
// Parametrised register file: 1 write / 2 read ports, zero register, const bypass on B, flag flop.
// Optional same-cycle write-to-read forwarding under `RF_FORWARD_EN.
module rf_param
  import rf_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] ptr_w,
  input  logic [W-1:0]  di,
  input  logic [AW-1:0] ptr_a,
  input  logic [W-1:0]  ptr_b,
  input  logic          const_flag,
  input  logic          flag_we,
  input  logic          flag_in,
  output logic [W-1:0]  do_a,
  output logic [W-1:0]  do_b,
  output logic [W-1:0]  store_value,
  output logic          flag_out,
  output logic          ready
);

  logic [W-1:0]  r_core [DEPTH];
  logic          r_flag;

  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic          w_ready;
  logic [AW-1:0] w_ptr_b;
  logic          w_wr_ok;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .ready    (w_ready)
  );

  assign w_ptr_b = ptr_b[AW-1:0];
  assign w_wr_ok = w_ready && we && (ptr_w != AW'(ZERO_REG));

  // No reset on the array so it can map onto RAM; the sweep provides the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clr_we) begin
        r_core[w_clr_addr] <= '0;
      end else if (w_wr_ok) begin
        r_core[ptr_w] <= di;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag <= 1'b0;
    end else if (w_ready && flag_we) begin
      r_flag <= flag_in;
    end
  end

  always_comb begin
    do_a        = '0;
    do_b        = '0;
    store_value = '0;
    flag_out    = r_flag;
    if (w_ready) begin
      if (ptr_a != AW'(ZERO_REG)) do_a = r_core[ptr_a];
      if (w_ptr_b != AW'(ZERO_REG)) do_b = r_core[w_ptr_b];
      if (ptr_w != AW'(ZERO_REG)) store_value = r_core[ptr_w];
`ifdef RF_FORWARD_EN
      if (w_wr_ok) begin
        if (ptr_a == ptr_w) do_a = di;
        if (w_ptr_b == ptr_w) do_b = di;
        store_value = di;
      end
      if (flag_we) flag_out = flag_in;
`endif
    end
    if (const_flag) do_b = ptr_b;
  end

  assign ready = w_ready;

endmodule

// File: tb/tb_rf_param.sv
// Directed self-checking bench for rf_param (DEPTH=8, W=8); honours `RF_FORWARD_EN.
module tb_rf_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       we = 1'b0;
  logic [2:0] ptr_w = '0;
  logic [7:0] di = '0;
  logic [2:0] ptr_a = '0;
  logic [7:0] ptr_b = '0;
  logic       const_flag = 1'b0;
  logic       flag_we = 1'b0;
  logic       flag_in = 1'b0;
  logic [7:0] do_a;
  logic [7:0] do_b;
  logic [7:0] store_value;
  logic       flag_out;
  logic       ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rf_param #(
    .W     (8),
    .DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .ptr_w       (ptr_w),
    .di          (di),
    .ptr_a       (ptr_a),
    .ptr_b       (ptr_b),
    .const_flag  (const_flag),
    .flag_we     (flag_we),
    .flag_in     (flag_in),
    .do_a        (do_a),
    .do_b        (do_b),
    .store_value (store_value),
    .flag_out    (flag_out),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] p, input logic [7:0] d);
    ptr_w = p;
    di    = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  // Counts edges until ready rises; bounded so a stuck sweep still reaches the summary.
  task automatic count_to_ready(output int unsigned n);
    n = 0;
    for (int unsigned k = 0; k < 20; k++) begin
      tick();
      n++;
      if (ready) break;
    end
    if (!ready) n = 99;
  endtask

  initial begin
    int unsigned cyc;
    logic [7:0]  exp_same;
    logic        exp_flag_pre;

    // 1. reset and clear sweep
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("ready_after_reset", ready, 1'b0);
    chk("flag_after_reset", flag_out, 1'b0);
    ptr_a = 3'd5;
    const_flag = 1'b1;
    ptr_b = 8'h6D;
    #1;
    chk("clear_do_a_zero", do_a, 8'h00);
    chk("clear_const_b", do_b, 8'h6D);
    const_flag = 1'b0;
    #1;
    chk("clear_do_b_zero", do_b, 8'h00);
    count_to_ready(cyc);
    chk("sweep_cycles", cyc, 7);
    for (int unsigned i = 0; i < 8; i++) begin
      ptr_a = 3'(i);
      ptr_b = 8'(i);
      ptr_w = 3'(i);
      #1;
      chk("init_do_a", do_a, 8'h00);
      chk("init_do_b", do_b, 8'h00);
      chk("init_store", store_value, 8'h00);
    end
    chk("init_flag", flag_out, 1'b0);

    // 2. write and read
    wr(3'd3, 8'hA5);
    wr(3'd7, 8'h3C);
    ptr_a = 3'd3;
    ptr_b = 8'd7;
    ptr_w = 3'd3;
    #1;
    chk("rd_a_3", do_a, 8'hA5);
    chk("rd_b_7", do_b, 8'h3C);
    chk("store_3", store_value, 8'hA5);

    // 3. zero register and constant bypass
    wr(3'd0, 8'hFF);
    ptr_a = 3'd0;
    ptr_w = 3'd0;
    #1;
    chk("zero_do_a", do_a, 8'h00);
    chk("zero_store", store_value, 8'h00);
    const_flag = 1'b1;
    ptr_b = 8'h9B;
    #1;
    chk("const_b", do_b, 8'h9B);
    const_flag = 1'b0;
    ptr_b = 8'hFB;
    #1;
    chk("b_upper_ignored", do_b, 8'hA5);

    // 4. flag with a concurrent write
    flag_we = 1'b1;
    flag_in = 1'b1;
    ptr_w = 3'd2;
    di = 8'h11;
    we = 1'b1;
    ptr_a = 3'd2;
    #1;
`ifdef RF_FORWARD_EN
    exp_flag_pre = 1'b1;
    exp_same     = 8'h11;
`else
    exp_flag_pre = 1'b0;
    exp_same     = 8'h00;
`endif
    chk("flag_pre_edge", flag_out, exp_flag_pre);
    chk("a_pre_edge_2", do_a, exp_same);
    tick();
    we = 1'b0;
    flag_we = 1'b0;
    flag_in = 1'b0;
    #1;
    chk("flag_set", flag_out, 1'b1);
    chk("rd_a_2", do_a, 8'h11);
    tick();
    chk("flag_hold", flag_out, 1'b1);
    flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
    chk("flag_clear", flag_out, 1'b0);

    // 5. reset mid-sweep, writes ignored while clearing
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_sweep_ready", ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ptr_w = 3'd3;
    di = 8'hEE;
    we = 1'b1;
    flag_we = 1'b1;
    flag_in = 1'b1;
    count_to_ready(cyc);
    we = 1'b0;
    flag_we = 1'b0;
    flag_in = 1'b0;
    chk("resweep_cycles", cyc, 7);
    ptr_a = 3'd3;
    ptr_b = 8'd7;
    #1;
    chk("sweep_wr_ignored", do_a, 8'h00);
    chk("sweep_cleared_7", do_b, 8'h00);
    chk("sweep_flag_ignored", flag_out, 1'b0);

    // 6. same-cycle read/write
    wr(3'd5, 8'h10);
    ptr_w = 3'd5;
    di = 8'h20;
    we = 1'b1;
    ptr_a = 3'd5;
    ptr_b = 8'd5;
    #1;
`ifdef RF_FORWARD_EN
    exp_same = 8'h20;
`else
    exp_same = 8'h10;
`endif
    chk("same_cyc_a", do_a, exp_same);
    chk("same_cyc_b", do_b, exp_same);
    chk("same_cyc_store", store_value, exp_same);
    tick();
    we = 1'b0;
    #1;
    chk("next_cyc_a", do_a, 8'h20);
    chk("next_cyc_store", store_value, 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
